// File: rtl/uart_record_loader_if.sv
// uart_record_loader_if: valid/ready record stream from the loader FIFO head to the input manager
// Signals: rec_valid (head present), rec_ready (consumer accepts head),
//          shape_addr/reg_addr/data (head record fields)
interface uart_record_loader_if #(
    parameter int SHAPE_ADDR_W = 11,
    parameter int REG_ADDR_W   = 12,
    parameter int DATA_W       = 12
);
    logic                    rec_valid;
    logic                    rec_ready;
    logic [SHAPE_ADDR_W-1:0] shape_addr;
    logic [REG_ADDR_W-1:0]   reg_addr;
    logic [DATA_W-1:0]       data;
    modport master (output rec_valid, shape_addr, reg_addr, data, input rec_ready);
    modport slave  (input rec_valid, shape_addr, reg_addr, data, output rec_ready);
endinterface

// File: rtl/uart_record_loader.sv
// uart_record_loader: 8N1 UART receiver that frames checksummed shape-register records into a FWFT FIFO
// Ports: clk; rst_n (async, active low); serial_input (RX line, idle high);
//        resume (pulse, clears overflow and err_count); rec (master side of the record stream);
//        program_out (programming window); overflow (sticky drop flag);
//        err_count (saturating abort count); fifo_level (records held)
module uart_record_loader #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int SHAPE_ADDR_W   = 11,
    parameter int REG_ADDR_W     = 12,
    parameter int DATA_W         = 12,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 16 * CLKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        serial_input,
    input  logic                        resume,
    uart_record_loader_if.master        rec,
    output logic                        program_out,
    output logic                        overflow,
    output logic [7:0]                  err_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int W  = SHAPE_ADDR_W + REG_ADDR_W + DATA_W;
    localparam int P  = (W + 7) / 8;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(P + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} ps_t;

    rx_t           r_rx, w_rx_nx;
    ps_t           r_ps, w_ps_nx;
    logic [1:0]    r_sync;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh, r_chk;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tmo;
    logic [W-1:0]  r_pay;
    logic          r_end;
    logic [W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [W-1:0]  w_head;
    logic          w_line, w_fall, w_half, w_full, w_byte_ok, w_frame_err, w_byte_ev, w_tmo;
    logic          w_good, w_err, w_set_end, w_store;
    logic          w_empty, w_fifo_full, w_pop, w_push, w_drop;

    // Synchronised line; r_prev resets low so a line still low after reset is never taken as a start edge
    assign w_line = r_sync[1];
    assign w_fall = r_prev & ~w_line;
    assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign w_full = r_cnt == CW'(CLKS_PER_BIT - 1);

    // RX state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_rx <= RX_IDLE;
        else        r_rx <= w_rx_nx;

    // RX next state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        w_rx_nx = r_rx;
        case (r_rx)
            RX_IDLE:  if (w_fall) w_rx_nx = RX_START;
            RX_START: if (w_half) w_rx_nx = w_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_bit == 3'd7) w_rx_nx = RX_STOP;
            default:  if (w_full) w_rx_nx = RX_IDLE;
        endcase
    end

    // RX outputs: one-cycle strobes at the mid-stop-bit sample
    always_comb begin
        w_byte_ok   = r_rx == RX_STOP && w_full && w_line;
        w_frame_err = r_rx == RX_STOP && w_full && !w_line;
    end

    // RX datapath; after the half-bit start sample every full count lands mid-bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sh   <= '0;
        end else begin
            r_sync <= {r_sync[0], serial_input};
            r_prev <= w_line;
            r_cnt  <= (r_rx == RX_IDLE || w_full || (r_rx == RX_START && w_half)) ? '0 : r_cnt + 1'b1;
            if (r_rx == RX_DATA && w_full) begin
                r_bit <= r_bit + 1'b1;
                r_sh  <= {w_line, r_sh[7:1]};
            end
        end

    assign w_byte_ev = w_byte_ok | w_frame_err;
    assign w_tmo     = r_ps != P_HUNT && !w_byte_ev && r_tmo == TW'(TIMEOUT_CYCLES - 1);

    // Parser state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_ps <= P_HUNT;
        else        r_ps <= w_ps_nx;

    // Parser next state; framing errors and timeouts abort from any state
    always_comb begin
        w_ps_nx = r_ps;
        if (w_frame_err || w_tmo)
            w_ps_nx = P_HUNT;
        else if (w_byte_ok)
            case (r_ps)
                P_HUNT:    w_ps_nx = r_sh == 8'hA5 ? P_PAYLOAD : P_HUNT;
                P_PAYLOAD: w_ps_nx = r_idx == IW'(P - 1) ? P_CHECK : P_PAYLOAD;
                default:   w_ps_nx = P_HUNT;
            endcase
    end

    // Parser outputs
    always_comb begin
        w_good    = w_byte_ok && r_ps == P_CHECK && r_sh == r_chk;
        w_err     = w_frame_err || w_tmo || (w_byte_ok && r_ps == P_CHECK && r_sh != r_chk);
        w_set_end = w_byte_ok && r_ps == P_HUNT && r_sh == 8'h5A;
        w_store   = w_byte_ok && r_ps == P_PAYLOAD;
    end

    // Parser datapath; only the W payload bits are kept, unused high bits of the last byte fall away
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_idx <= '0;
            r_chk <= '0;
            r_tmo <= '0;
            r_pay <= '0;
        end else begin
            r_idx <= r_ps == P_HUNT ? '0 : r_idx + IW'(w_store);
            r_chk <= r_ps == P_HUNT ? '0 : w_store ? r_chk ^ r_sh : r_chk;
            r_tmo <= (r_ps == P_HUNT || w_byte_ev) ? '0 : r_tmo + 1'b1;
            if (w_store)
                for (int i = 0; i < W; i++)
                    if (r_idx == IW'(i / 8)) r_pay[i] <= r_sh[3'(i % 8)];
        end

    // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO
    assign w_empty     = fifo_level == '0;
    assign w_fifo_full = fifo_level == LW'(FIFO_DEPTH);
    assign w_pop       = !w_empty && rec.rec_ready;
    assign w_push      = w_good && (!w_fifo_full || w_pop);
    assign w_drop      = w_good && w_fifo_full && !w_pop;
    assign w_head      = w_empty ? '0 : r_mem[r_rd];
    assign rec.rec_valid = !w_empty;
    assign {rec.data, rec.reg_addr, rec.shape_addr} = w_head;

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= r_pay;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            fifo_level <= '0;
        end else begin
            r_wr       <= r_wr + AW'(w_push);
            r_rd       <= r_rd + AW'(w_pop);
            fifo_level <= fifo_level + LW'(w_push) - LW'(w_pop);
        end

    // Status; a set in the same cycle as resume wins over the clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_end       <= 1'b0;
            program_out <= 1'b0;
            overflow    <= 1'b0;
            err_count   <= '0;
        end else begin
            r_end       <= w_good ? 1'b0 : w_set_end ? 1'b1 : (r_end && w_empty) ? 1'b0 : r_end;
            program_out <= w_good ? 1'b1 : (r_end && w_empty) ? 1'b0 : program_out;
            overflow    <= w_drop ? 1'b1 : resume ? 1'b0 : overflow;
            err_count   <= w_err ? (resume ? 8'd1 : err_count + 8'(err_count != 8'hFF)) :
                           resume ? 8'd0 : err_count;
        end
endmodule

// File: doc/uart_record_loader.md
# uart_record_loader

Parametrised successor to the scene-input UART front end. Receives 8N1 serial bytes, frames them into checksummed shape-register write records, and buffers validated records in a first-word-fall-through FIFO drained through a valid/ready handshake by the input manager. Also tracks the scene-programming window (`program_out`) and reports overflow and corrupt-packet statistics.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4
- SHAPE_ADDR_W, 11: shape address width
- REG_ADDR_W, 12: register address width
- DATA_W, 12: data width
- FIFO_DEPTH, 16: record FIFO depth, power of two ≥ 2
- TIMEOUT_CYCLES, 16*CLKS_PER_BIT: max idle gap between bytes inside a packet

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- serial_input  in  1  UART RX line, asynchronous, idle high
- resume  in  1  single-cycle pulse; clears `overflow` and `err_count`
- rec_ready  in  1  consumer accepts the head record
- rec_valid  out  1  FIFO non-empty
- shape_addr  out  SHAPE_ADDR_W  head record shape address
- reg_addr  out  REG_ADDR_W  head record register address
- data  out  DATA_W  head record data
- program_out  out  1  scene-programming window active
- overflow  out  1  sticky: a valid record was dropped because the FIFO was full
- err_count  out  8  saturating count of checksum/framing/timeout aborts
- fifo_level  out  $clog2(FIFO_DEPTH)+1  records held

## Operation
- RX: 2-flop synchroniser. Falling edge in IDLE starts START; line re-sampled at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE. Then 8 data bits LSB-first, each sampled at CLKS_PER_BIT intervals, then STOP. Stop bit 0 is a framing error: byte dropped, parser aborts, err_count +1.
- Payload W = SHAPE_ADDR_W+REG_ADDR_W+DATA_W (35 by default). P = ceil(W/8) bytes (5). Bits packed {data, reg_addr, shape_addr}, shape_addr in LSBs. Byte 0 = bits[7:0]. Unused high bits of the last byte are ignored.
- Parser states:
  - HUNT: 0xA5 → PAYLOAD with index 0. 0x5A → set end_pending, stay in HUNT. Any other byte is ignored.
  - PAYLOAD: store byte, XOR into running check; after byte P-1 → CHECK.
  - CHECK: byte equals XOR of payload bytes → push record, clear end_pending, set program_out; otherwise err_count +1. Return to HUNT either way.
- Timeout: in PAYLOAD/CHECK, if TIMEOUT_CYCLES pass with no completed byte, return to HUNT and err_count +1.
- Push with FIFO full: record dropped, overflow ← 1, FIFO untouched.
- program_out clears on the cycle after end_pending=1 and FIFO empty are both true; end_pending clears with it.
- err_count saturates at 255.
- resume clears overflow and err_count. If the same cycle also sets one of them, the set wins (overflow=1, err_count=1).

## Timing
- Reset values: rec_valid 0, shape_addr/reg_addr/data 0, program_out 0, overflow 0, err_count 0, fifo_level 0; parser in HUNT, RX in IDLE, FIFO empty, end_pending 0.
- Byte strobe: mid-stop-bit sample. The push into the FIFO is registered on that strobe cycle; rec_valid is high on the next cycle.
- Outputs show the head record combinationally from FIFO storage. Pop on rec_valid && rec_ready.
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and there is no overflow. When empty, the push is seen next cycle and the pop is ignored.
- fifo_level is registered and equals occupancy after the current cycle's push/pop.
- Reset mid-byte or mid-packet: all partial state is discarded. After release the line must be seen idle-high before a new start bit is accepted.

## Test plan
(CLKS_PER_BIT=16, FIFO_DEPTH=4, default widths)
- Single record: send A5, payload for shape 0x123 / reg 0x456 / data 0x789, correct XOR. Hold rec_ready=0 → rec_valid=1 with exactly those fields, program_out=1, fifo_level=1. Pulse rec_ready → fifo_level=0.
- Bad checksum: same packet with checksum^0x01 → no record, err_count=1. A following good packet is accepted normally.
- Overflow: 5 good packets with rec_ready=0 → fifo_level=4, overflow=1, head is packet 1. Pulse resume → overflow=0.
- End of program: good packet, then 5A, then drain → program_out falls the cycle after fifo_level reaches 0. A second good packet sent after 5A but before draining keeps program_out=1.
- Robustness:
  - Stop bit forced low → err_count +1.
  - 4-cycle low glitch → no byte received.
  - 17×16-cycle gap after byte 2 → timeout, err_count +1.
  - rst_n pulsed mid-payload → all outputs 0 and the next full packet is accepted.
